bc_rx_deserializer: RTL and testbench

Receive-side counterpart to the breadcrumb transmit path. Accepts the asynchronous single-wire serial stream from the Arduino link, recovers 16-bit breadcrumb words, and presents them to Avoidance with a valid/ready handshake. Sits between the Arduino RX pin and the Avoidance logic, opposite the existing buffer/serializer path that drives the link.

---
 rtl/bc_rx_deserializer.sv | 171 +++++++++++++++++
 tb/tb_bc_rx_deserializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_rx_deserializer.sv
// bc_rx_deserializer
// Receives 16-bit breadcrumb words from the Arduino serial link and hands them
// to Avoidance over a valid/ready handshake.
// Frame: start(0), 16 data bits LSB first, [even parity], stop(1).
// Optional feature: define BC_RX_PARITY_EN to expect and check a parity bit.
module bc_rx_deserializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  input  logic        avoid_rdy,
  output logic [15:0] bc_out,
  output logic        bc_valid,
  output logic        framing_err,
  output logic        parity_err,
  output logic        overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              sync_p0;
  logic              sync_p1;
  logic              rx_s;
  logic [CNT_W-1:0]  baud_cnt;
  logic [3:0]        bit_idx;
  logic [15:0]       shift_reg;
  logic              half_hit;
  logic              full_hit;
  logic              shift_en;
  logic              stop_en;
  logic              par_bad;
  logic              commit_req;
  logic              ferr_evt;
  logic              cnt_clr;
`ifdef BC_RX_PARITY_EN
  logic              par_bit;
  logic              par_en;
  logic              perr_evt;
`endif

  assign rx_s     = sync_p1;
  assign half_hit = (baud_cnt == HALF_M1);
  assign full_hit = (baud_cnt == FULL_M1);

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= serial_in;
      sync_p1 <= sync_p0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nxt = S_START;
      S_START:     if (half_hit) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (full_hit && (bit_idx == 4'd15)) begin
`ifdef BC_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY:    if (full_hit) state_nxt = S_STOP;
      S_STOP:      if (full_hit) state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // FSM output strobes: sample enables, frame verdicts, counter clear
  always_comb begin
    shift_en   = (state == S_DATA) && full_hit;
    stop_en    = (state == S_STOP) && full_hit;
`ifdef BC_RX_PARITY_EN
    par_en     = (state == S_PARITY) && full_hit;
    par_bad    = ^{shift_reg, par_bit};
    perr_evt   = stop_en && rx_s && par_bad;
`else
    par_bad    = 1'b0;
`endif
    commit_req = stop_en && rx_s && !par_bad;
    ferr_evt   = stop_en && !rx_s;
    // Counters restart on every state entry and after each data bit sample;
    // they are held at zero while waiting for the line.
    cnt_clr    = (state_nxt != state) || shift_en ||
                 (state == S_IDLE) || (state == S_WAIT_IDLE);
  end

  // Baud and bit-index counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
      if (state_nxt != state) bit_idx <= '0;
      else if (shift_en)      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Data capture: each sampled bit lands at its own index, so no reset needed
  always_ff @(posedge clk) begin
    if (shift_en) shift_reg[bit_idx] <= rx_s;
`ifdef BC_RX_PARITY_EN
    if (par_en) par_bit <= rx_s;
`endif
  end

  // Output word, valid flag and one-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc_out      <= 16'h0000;
      bc_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef BC_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      framing_err <= ferr_evt;
      overrun     <= 1'b0;
`ifdef BC_RX_PARITY_EN
      parity_err  <= perr_evt;
`endif
      if (commit_req) begin
        // A word consumed in this same cycle frees the slot for the new one
        if (!bc_valid || avoid_rdy) begin
          bc_out   <= shift_reg;
          bc_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (bc_valid && avoid_rdy) begin
        bc_valid <= 1'b0;
      end
    end
  end

`ifndef BC_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bc_rx_deserializer.sv
// Directed bench for bc_rx_deserializer at CLKS_PER_BIT = 16.
// Honors BC_RX_PARITY_EN the same way the design does.
module tb_bc_rx_deserializer;

  localparam int CPB = 16;
`ifdef BC_RX_PARITY_EN
  localparam int COMMIT_OFS = 298;
`else
  localparam int COMMIT_OFS = 282;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        serial_in = 1'b1;
  logic        avoid_rdy = 1'b0;
  logic [15:0] bc_out;
  logic        bc_valid;
  logic        framing_err;
  logic        parity_err;
  logic        overrun;

  always #5 clk = ~clk;

  bc_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .avoid_rdy   (avoid_rdy),
    .bc_out      (bc_out),
    .bc_valid    (bc_valid),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .overrun     (overrun)
  );

  // Event monitor: running totals, sampled away from the active edge
  int          n_rise = 0, n_vhi = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
  logic [15:0] last_word = 16'h0000;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (bc_valid && !prev_v) begin
      n_rise    <= n_rise + 1;
      last_word <= bc_out;
    end
    if (bc_valid)    n_vhi  <= n_vhi + 1;
    if (framing_err) n_ferr <= n_ferr + 1;
    if (parity_err)  n_perr <= n_perr + 1;
    if (overrun)     n_ovr  <= n_ovr + 1;
    prev_v <= bc_valid;
  end

  int n_cmp = 0, n_bad = 0;
  int b_rise, b_vhi, b_ferr, b_perr, b_ovr;

  typedef struct {
    logic [15:0] word;
    logic        par;
    logic        stop;
    logic        rdy;
    int          exp_rise;
    logic [15:0] exp_word;
    int          exp_ferr;
    int          exp_perr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic take_base();
    b_rise = n_rise; b_vhi = n_vhi; b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr;
  endtask

  // Drives one frame; leaves the line at the stop-bit level
  task automatic send_frame(input logic [15:0] w, input logic p, input logic s);
    $display("tx frame %h par %b stop %b", w, p, s);
    serial_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 16; i++) begin
      serial_in = w[i];
      wait_cyc(CPB);
    end
`ifdef BC_RX_PARITY_EN
    serial_in = p;
    wait_cyc(CPB);
`endif
    serial_in = s;
    wait_cyc(CPB);
  endtask

  initial begin
    // word, parity bit (even), stop, rdy, exp rises, exp last word, exp ferr, exp perr
    vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 1'b1, 1, 16'hA5C3, 0, 0};
    vecs[1] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1, 16'h0000, 0, 0};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 1, 16'hFFFF, 0, 0};
    vecs[3] = '{16'h8001, 1'b0, 1'b1, 1'b1, 1, 16'h8001, 0, 0};
    vecs[4] = '{16'h1234, 1'b1, 1'b0, 1'b1, 0, 16'h8001, 1, 0};
`ifdef BC_RX_PARITY_EN
    vecs[5] = '{16'h0003, 1'b1, 1'b1, 1'b1, 0, 16'h8001, 0, 1};
`else
    vecs[5] = '{16'h0003, 1'b0, 1'b1, 1'b1, 1, 16'h0003, 0, 0};
`endif

    // Reset values
    wait_cyc(3);
    chk("reset bc_out", bc_out, 16'h0000);
    chk("reset bc_valid", bc_valid, 0);
    chk("reset framing_err", framing_err, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset overrun", overrun, 0);
    rst = 1'b1;

    // Idle line for 1000 cycles
    take_base();
    wait_cyc(1000);
    #1;
    chk("idle rises", n_rise - b_rise, 0);
    chk("idle errors", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);
    chk("idle bc_out", bc_out, 16'h0000);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      take_base();
      avoid_rdy = vecs[i].rdy;
      send_frame(vecs[i].word, vecs[i].par, vecs[i].stop);
      serial_in = 1'b1;
      wait_cyc(2 * CPB);
      #1;
      chk($sformatf("vec%0d rises", i), n_rise - b_rise, vecs[i].exp_rise);
      chk($sformatf("vec%0d valid cycles", i), n_vhi - b_vhi, vecs[i].exp_rise);
      chk($sformatf("vec%0d word", i), last_word, vecs[i].exp_word);
      chk($sformatf("vec%0d framing", i), n_ferr - b_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d parity", i), n_perr - b_perr, vecs[i].exp_perr);
      chk($sformatf("vec%0d overrun", i), n_ovr - b_ovr, 0);
    end

    // Back-to-back frames with Avoidance stalled: second word dropped
    wait_cyc(1);
    take_base();
    avoid_rdy = 1'b0;
    send_frame(16'h0001, 1'b1, 1'b1);
    send_frame(16'hFFFF, 1'b0, 1'b1);
    serial_in = 1'b1;
    wait_cyc(CPB);
    #1;
    chk("b2b rises", n_rise - b_rise, 1);
    chk("b2b overrun", n_ovr - b_ovr, 1);
    chk("b2b bc_out", bc_out, 16'h0001);
    chk("b2b bc_valid", bc_valid, 1);
    avoid_rdy = 1'b1;
    wait_cyc(1);
    chk("b2b valid after rdy", bc_valid, 0);
    chk("b2b bc_out kept", bc_out, 16'h0001);
    avoid_rdy = 1'b0;
    wait_cyc(CPB);

    // Commit coinciding with the handshake
    take_base();
    send_frame(16'h00FF, 1'b0, 1'b1);
    serial_in = 1'b1;
    wait_cyc(CPB);
    chk("coin first valid", bc_valid, 1);
    chk("coin first word", bc_out, 16'h00FF);
    fork
      send_frame(16'h0F00, 1'b0, 1'b1);
      begin
        wait_cyc(COMMIT_OFS);
        avoid_rdy = 1'b1;
        wait_cyc(1);
        avoid_rdy = 1'b0;
      end
    join
    serial_in = 1'b1;
    wait_cyc(CPB);
    #1;
    chk("coin bc_valid", bc_valid, 1);
    chk("coin bc_out", bc_out, 16'h0F00);
    chk("coin overrun", n_ovr - b_ovr, 0);
    avoid_rdy = 1'b1;
    wait_cyc(2);

    // Framing error followed by a break, then a good frame
    take_base();
    send_frame(16'h1234, 1'b1, 1'b0);
    wait_cyc(100);
    serial_in = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(16'h5678, 1'b0, 1'b1);
    serial_in = 1'b1;
    wait_cyc(2 * CPB);
    #1;
    chk("break framing", n_ferr - b_ferr, 1);
    chk("break rises", n_rise - b_rise, 1);
    chk("break word", last_word, 16'h5678);
    chk("break overrun", n_ovr - b_ovr, 0);

    // Short glitch on the idle line
    wait_cyc(1);
    take_base();
    serial_in = 1'b0;
    wait_cyc(4);
    serial_in = 1'b1;
    wait_cyc(2 * CPB);
    #1;
    chk("glitch rises", n_rise - b_rise, 0);
    chk("glitch errors", (n_ferr - b_ferr) + (n_perr - b_perr), 0);

    // Reset in the middle of the data bits
    wait_cyc(1);
    avoid_rdy = 1'b0;
    send_frame(16'hA5C3, 1'b0, 1'b1);
    serial_in = 1'b1;
    wait_cyc(CPB);
    chk("pre-reset valid", bc_valid, 1);
    chk("pre-reset word", bc_out, 16'hA5C3);
    serial_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 5; i++) begin
      serial_in = 1'b1;
      wait_cyc(CPB);
    end
    take_base();
    rst = 1'b0;
    #1;
    chk("midreset bc_valid", bc_valid, 0);
    chk("midreset bc_out", bc_out, 16'h0000);
    wait_cyc(3);
    serial_in = 1'b1;
    wait_cyc(1);
    rst = 1'b1;
    avoid_rdy = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(16'h5678, 1'b0, 1'b1);
    serial_in = 1'b1;
    wait_cyc(2 * CPB);
    #1;
    chk("postreset rises", n_rise - b_rise, 1);
    chk("postreset word", last_word, 16'h5678);
    chk("postreset errors", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
